// File: rtl/titan_div_sequencer_pkg.sv
// Shared encodings and helpers for the titan_div_sequencer divide unit.
package titan_div_sequencer_pkg;

  localparam logic [1:0] TITAN_DIV_DIV  = 2'd0;
  localparam logic [1:0] TITAN_DIV_DIVU = 2'd1;
  localparam logic [1:0] TITAN_DIV_REM  = 2'd2;
  localparam logic [1:0] TITAN_DIV_REMU = 2'd3;

  localparam int unsigned DivIters = 32;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StBusy = 2'd1,
    StDone = 2'd2
  } div_state_e;

  function automatic logic is_signed_op(logic [1:0] funct);
    return (funct == TITAN_DIV_DIV) || (funct == TITAN_DIV_REM);
  endfunction

  function automatic logic is_rem_op(logic [1:0] funct);
    return (funct == TITAN_DIV_REM) || (funct == TITAN_DIV_REMU);
  endfunction

  // Sign fixup plus the divide-by-zero and signed-overflow overrides.
  function automatic logic [31:0] fix_result(logic rem_sel, logic sign_a, logic sign_b,
                                             logic [31:0] mag_a, logic [31:0] mag_b,
                                             logic [31:0] quo, logic [31:0] rem);
    logic        div0;
    logic        ovf;
    logic [31:0] dividend;
    logic [31:0] q;
    logic [31:0] r;
    div0     = (mag_b == 32'd0);
    ovf      = sign_a & sign_b & (mag_a == 32'h8000_0000) & (mag_b == 32'd1);
    dividend = sign_a ? (32'd0 - mag_a) : mag_a;
    if (div0) begin
      q = 32'hFFFF_FFFF;
      r = dividend;
    end else if (ovf) begin
      q = 32'h8000_0000;
      r = 32'd0;
    end else begin
      q = (sign_a ^ sign_b) ? (32'd0 - quo) : quo;
      r = sign_a ? (32'd0 - rem) : rem;
    end
    return rem_sel ? r : q;
  endfunction

endpackage

// File: rtl/titan_div_sequencer_if.sv
// EX-stage divide request / result bundle between the pipeline and titan_div_sequencer.
interface titan_div_sequencer_if;
  logic        ex_div_op_i;
  logic [1:0]  ex_div_funct_i;
  logic [31:0] ex_port_a_i;
  logic [31:0] ex_port_b_i;
  logic        ex_kill_i;
  logic        mem_stall_i;
  logic        div_stall_o;
  logic        div_done_o;
  logic [31:0] div_result_o;

  modport master (
    output ex_div_op_i, ex_div_funct_i, ex_port_a_i, ex_port_b_i, ex_kill_i, mem_stall_i,
    input  div_stall_o, div_done_o, div_result_o
  );

  modport slave (
    input  ex_div_op_i, ex_div_funct_i, ex_port_a_i, ex_port_b_i, ex_kill_i, mem_stall_i,
    output div_stall_o, div_done_o, div_result_o
  );
endinterface

// File: rtl/titan_div_datapath.sv
// Restoring shift-subtract step, operand latching and result fixup.
// TITAN_DIV_BYPASS_EN: divide-by-zero and signed overflow are resolved at load time.
module titan_div_datapath
  import titan_div_sequencer_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        i_load,
  input  logic        i_step,
  input  logic        i_fix,
  input  logic [1:0]  i_funct,
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  output logic        o_bypass,
  output logic [31:0] o_result
);

  logic        r_rem_sel, r_sign_a, r_sign_b;
  logic [31:0] r_mag_a, r_mag_b, r_rem, r_quo, r_result;

  logic        w_signed, w_sign_a, w_sign_b, w_no_borrow;
  logic [31:0] w_mag_a, w_mag_b, w_rem_step, w_quo_step;
  logic [32:0] w_shift, w_diff;

  assign w_signed = is_signed_op(i_funct);
  assign w_sign_a = w_signed & i_a[31];
  assign w_sign_b = w_signed & i_b[31];
  assign w_mag_a  = w_sign_a ? (32'd0 - i_a) : i_a;
  assign w_mag_b  = w_sign_b ? (32'd0 - i_b) : i_b;

  // 33-bit partial remainder so unsigned divisors >= 2^31 still compare correctly.
  assign w_shift     = {r_rem, r_quo[31]};
  assign w_diff      = w_shift - {1'b0, r_mag_b};
  assign w_no_borrow = ~w_diff[32];
  assign w_rem_step  = w_no_borrow ? w_diff[31:0] : w_shift[31:0];
  assign w_quo_step  = {r_quo[30:0], w_no_borrow};

`ifdef TITAN_DIV_BYPASS_EN
  assign o_bypass = (w_mag_b == 32'd0) |
                    (w_sign_a & w_sign_b & (w_mag_a == 32'h8000_0000) & (w_mag_b == 32'd1));
`else
  assign o_bypass = 1'b0;
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_rem_sel <= 1'b0;
      r_sign_a  <= 1'b0;
      r_sign_b  <= 1'b0;
      r_mag_a   <= 32'd0;
      r_mag_b   <= 32'd0;
      r_rem     <= 32'd0;
      r_quo     <= 32'd0;
      r_result  <= 32'd0;
    end else begin
      if (i_load) begin
        r_rem_sel <= is_rem_op(i_funct);
        r_sign_a  <= w_sign_a;
        r_sign_b  <= w_sign_b;
        r_mag_a   <= w_mag_a;
        r_mag_b   <= w_mag_b;
        r_rem     <= 32'd0;
        r_quo     <= w_mag_a;
      end else if (i_step) begin
        r_rem <= w_rem_step;
        r_quo <= w_quo_step;
      end
      if (i_load && o_bypass) begin
        r_result <= fix_result(is_rem_op(i_funct), w_sign_a, w_sign_b, w_mag_a, w_mag_b,
                               32'd0, 32'd0);
      end else if (i_fix) begin
        r_result <= fix_result(r_rem_sel, r_sign_a, r_sign_b, r_mag_a, r_mag_b,
                               w_quo_step, w_rem_step);
      end
    end
  end

  assign o_result = r_result;

endmodule

// File: rtl/titan_div_sequencer.sv
// Multi-cycle RV32M divide controller: FSM, iteration counter, stall and done generation.
// Optional early completion for trivial cases under TITAN_DIV_BYPASS_EN (see datapath).
module titan_div_sequencer
  import titan_div_sequencer_pkg::*;
(
  input logic                  clk_i,
  input logic                  rst_i,
  titan_div_sequencer_if.slave bus
);

  localparam logic [4:0] LastIter = 5'(DivIters - 1);

  div_state_e  r_state, w_state_d;
  logic [4:0]  r_cnt;
  logic        w_start, w_load, w_step, w_fix, w_bypass;
  logic [31:0] w_result;

  assign w_start = bus.ex_div_op_i & ~bus.ex_kill_i;

  always_comb begin
    w_state_d = r_state;
    w_load    = 1'b0;
    w_step    = 1'b0;
    w_fix     = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (w_start) begin
          w_load    = 1'b1;
          w_state_d = w_bypass ? StDone : StBusy;
        end
      end
      StBusy: begin
        if (bus.ex_kill_i) begin
          w_state_d = StIdle;
        end else begin
          w_step = 1'b1;
          if (r_cnt == LastIter) begin
            w_fix     = 1'b1;
            w_state_d = StDone;
          end
        end
      end
      StDone: begin
        // A held ex_div_op_i is the same instruction, so it is never restarted here.
        if (bus.ex_kill_i || !bus.mem_stall_i) w_state_d = StIdle;
      end
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= StIdle;
      r_cnt   <= 5'd0;
    end else begin
      r_state <= w_state_d;
      if (w_load)      r_cnt <= 5'd0;
      else if (w_step) r_cnt <= r_cnt + 5'd1;
    end
  end

  titan_div_datapath u_datapath (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .i_load   (w_load),
    .i_step   (w_step),
    .i_fix    (w_fix),
    .i_funct  (bus.ex_div_funct_i),
    .i_a      (bus.ex_port_a_i),
    .i_b      (bus.ex_port_b_i),
    .o_bypass (w_bypass),
    .o_result (w_result)
  );

  assign bus.div_stall_o  = (r_state == StBusy) | ((r_state == StIdle) & w_start);
  assign bus.div_done_o   = (r_state == StDone);
  assign bus.div_result_o = w_result;

endmodule

// File: tb/tb_titan_div_sequencer.sv
// Randomized self-checking bench for titan_div_sequencer against an RV32M arithmetic model.
module tb_titan_div_sequencer;
  import titan_div_sequencer_pkg::*;

`ifdef TITAN_DIV_BYPASS_EN
  localparam bit Bypass = 1'b1;
`else
  localparam bit Bypass = 1'b0;
`endif

  logic clk;
  logic rst;
  int   n_checks;
  int   n_pass;

  titan_div_sequencer_if u_if ();

  titan_div_sequencer dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (u_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic logic [31:0] ref_result(logic [1:0] f, logic [31:0] a, logic [31:0] b);
    int  sa;
    int  sb;
    logic ovf;
    sa  = a;
    sb  = b;
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (f)
      TITAN_DIV_DIV:  return (b == 0) ? 32'hFFFF_FFFF : ovf ? 32'h8000_0000 : 32'(sa / sb);
      TITAN_DIV_DIVU: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      TITAN_DIV_REM:  return (b == 0) ? a : ovf ? 32'd0 : 32'(sa % sb);
      default:        return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int ref_latency(logic [1:0] f, logic [31:0] a, logic [31:0] b);
    logic special;
    special = (b == 0) || (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
    return (Bypass && special) ? 1 : 33;
  endfunction

  // One complete divide: issue at cycle 0, hold mem_stall for n_stall cycles from DONE.
  task automatic do_op(input logic [1:0] f, input logic [31:0] a, input logic [31:0] b,
                       input int n_stall, input string tag);
    logic [31:0] exp;
    int          lat;
    int          bad;
    exp = ref_result(f, a, b);
    lat = ref_latency(f, a, b);
    bad = 0;
    @(negedge clk);
    u_if.ex_div_op_i    = 1'b1;
    u_if.ex_div_funct_i = f;
    u_if.ex_port_a_i    = a;
    u_if.ex_port_b_i    = b;
    u_if.mem_stall_i    = 1'b0;
    #1 check_eq({tag, " stall_c0"}, 32'(u_if.div_stall_o), 32'd1);
    for (int c = 1; c < lat; c++) begin
      @(negedge clk);
      if (u_if.div_done_o !== 1'b0 || u_if.div_stall_o !== 1'b1) bad++;
    end
    check_eq({tag, " busy_window"}, 32'(bad), 32'd0);
    @(negedge clk);
    u_if.mem_stall_i = (n_stall > 0);
    #1;
    check_eq({tag, " done"}, 32'(u_if.div_done_o), 32'd1);
    check_eq({tag, " stall_done"}, 32'(u_if.div_stall_o), 32'd0);
    check_eq({tag, " result"}, u_if.div_result_o, exp);
    bad = 0;
    for (int s = 1; s <= n_stall; s++) begin
      @(negedge clk);
      u_if.mem_stall_i = (s < n_stall);
      #1 if (u_if.div_done_o !== 1'b1 || u_if.div_result_o !== exp) bad++;
    end
    if (n_stall > 0) check_eq({tag, " hold"}, 32'(bad), 32'd0);
    @(negedge clk);
    u_if.ex_div_op_i = 1'b0;
    #1 check_eq({tag, " idle"}, {30'd0, u_if.div_done_o, u_if.div_stall_o}, 32'd0);
  endtask

  initial begin
    logic [1:0]  f;
    logic [31:0] a;
    logic [31:0] b;
    int          bad;
    n_checks = 0;
    n_pass   = 0;
    rst                 = 1'b1;
    u_if.ex_div_op_i    = 1'b0;
    u_if.ex_div_funct_i = 2'd0;
    u_if.ex_port_a_i    = 32'd0;
    u_if.ex_port_b_i    = 32'd0;
    u_if.ex_kill_i      = 1'b0;
    u_if.mem_stall_i    = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("reset done", 32'(u_if.div_done_o), 32'd0);
    check_eq("reset stall", 32'(u_if.div_stall_o), 32'd0);
    check_eq("reset result", u_if.div_result_o, 32'd0);
    rst = 1'b0;

    do_op(TITAN_DIV_DIV,  32'd100,         32'd7,          0, "div_100_7");
    do_op(TITAN_DIV_REM,  32'hFFFF_FFF9,   32'd2,          0, "rem_m7_2");
    do_op(TITAN_DIV_REMU, 32'hFFFF_FFF9,   32'd2,          0, "remu_m7_2");
    do_op(TITAN_DIV_DIVU, 32'd5,           32'd0,          0, "divu_5_0");
    do_op(TITAN_DIV_REM,  32'd5,           32'd0,          0, "rem_5_0");
    do_op(TITAN_DIV_DIV,  32'h8000_0000,   32'hFFFF_FFFF,  0, "div_ovf");
    do_op(TITAN_DIV_REM,  32'h8000_0000,   32'hFFFF_FFFF,  0, "rem_ovf");
    do_op(TITAN_DIV_DIVU, 32'hFFFF_FFFE,   32'h8000_0001,  0, "divu_bigdiv");
    do_op(TITAN_DIV_DIV,  32'hFFFF_FF9C,   32'd7,          4, "div_mstall");

    // Kill mid-operation, then a fresh divide two cycles later.
    @(negedge clk);
    u_if.ex_div_op_i    = 1'b1;
    u_if.ex_div_funct_i = TITAN_DIV_DIV;
    u_if.ex_port_a_i    = 32'd1000;
    u_if.ex_port_b_i    = 32'd7;
    bad = 0;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (u_if.div_done_o !== 1'b0) bad++;
    end
    u_if.ex_kill_i = 1'b1;
    #1 check_eq("kill c10 stall", 32'(u_if.div_stall_o), 32'd1);
    @(negedge clk);
    u_if.ex_kill_i   = 1'b0;
    u_if.ex_div_op_i = 1'b0;
    #1;
    check_eq("kill c11 stall", 32'(u_if.div_stall_o), 32'd0);
    if (u_if.div_done_o !== 1'b0) bad++;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (u_if.div_done_o !== 1'b0) bad++;
    end
    check_eq("kill no_done", 32'(bad), 32'd0);
    do_op(TITAN_DIV_DIV, 32'd9, 32'd3, 0, "div_9_3_after_kill");

    // Kill in the start cycle drops the stall combinationally.
    @(negedge clk);
    u_if.ex_div_op_i = 1'b1;
    u_if.ex_kill_i   = 1'b1;
    #1 check_eq("kill_start stall", 32'(u_if.div_stall_o), 32'd0);
    @(negedge clk);
    u_if.ex_div_op_i = 1'b0;
    u_if.ex_kill_i   = 1'b0;
    #1 check_eq("kill_start idle", {30'd0, u_if.div_done_o, u_if.div_stall_o}, 32'd0);

    // Asynchronous reset mid-operation.
    @(negedge clk);
    u_if.ex_div_op_i    = 1'b1;
    u_if.ex_div_funct_i = TITAN_DIV_DIVU;
    u_if.ex_port_a_i    = 32'd77;
    u_if.ex_port_b_i    = 32'd5;
    repeat (5) @(negedge clk);
    u_if.ex_div_op_i = 1'b0;
    rst = 1'b1;
    #1;
    check_eq("rst_mid stall", 32'(u_if.div_stall_o), 32'd0);
    check_eq("rst_mid done", 32'(u_if.div_done_o), 32'd0);
    check_eq("rst_mid result", u_if.div_result_o, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 40; i++) begin
      f = 2'($urandom_range(0, 3));
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 5))
        0: begin a = $urandom_range(0, 500); b = $urandom_range(1, 20); end
        1: b = 32'd0;
        2: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        3: ;
        4: b = b | 32'h8000_0000;
        default: begin a = 32'd0 - $urandom_range(1, 1000); b = $urandom_range(1, 50); end
      endcase
      do_op(f, a, b, $urandom_range(0, 3), $sformatf("rand%0d", i));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/titan_div_sequencer.md
# titan_div_sequencer

Multi-cycle integer divide controller for the execute stage. It accepts RV32M DIV/DIVU/REM/REMU operands beside the single-cycle ALU and runs a 32-iteration restoring shift-subtract division. While busy it holds the pipeline through the hazard unit, and it presents the result to the EX/MEM register for exactly the instruction that started it.

## Interface
- No parameters (width fixed at 32).
- clk_i  in  1  core clock.
- rst_i  in  1  reset; asynchronous, active-high.
- ex_div_op_i  in  1  divide-class instruction valid in EX.
- ex_div_funct_i  in  2  0=DIV, 1=DIVU, 2=REM, 3=REMU.
- ex_port_a_i  in  32  dividend (rs1).
- ex_port_b_i  in  32  divisor (rs2).
- ex_kill_i  in  1  EX flush (trap, branch redirect); aborts any operation.
- mem_stall_i  in  1  downstream stall; EX instruction is not advancing.
- div_stall_o  out  1  to hazard unit; freezes IF/ID/EX while a divide is pending.
- div_done_o  out  1  result valid this cycle.
- div_result_o  out  32  quotient or remainder, selected by latched funct.

## Operation
- States: IDLE, BUSY, DONE.
- IDLE:
  - On ex_div_op_i & !ex_kill_i, latch the funct, the operand signs and the operand magnitudes (unsigned ops: sign=0, magnitude=operand). Clear the 32-bit remainder register, load the quotient register with |dividend|, clear the 5-bit counter, and go to BUSY.
- BUSY: one iteration per cycle.
  - rem_next = {rem[30:0], quo[31]} minus |divisor|.
  - If the subtraction does not borrow, commit it and shift 1 into quo; otherwise keep the shifted value and shift 0.
  - Go to DONE after the iteration with counter==31.
- Result fixup, registered on entry to DONE:
  - Quotient is negated if the signs differ and divisor != 0.
  - Remainder is negated if the dividend sign is set.
  - Divisor==0: quotient=0xFFFFFFFF and remainder=dividend, for all four ops.
  - Signed overflow (0x80000000 / 0xFFFFFFFF, DIV/REM): quotient=0x80000000, remainder=0.
- DONE: div_done_o=1.
  - If mem_stall_i, stay in DONE holding the result.
  - Else go to IDLE.
  - ex_div_op_i is ignored in DONE, so the same instruction is never restarted.
- ex_kill_i in any state: go to IDLE next cycle and discard the result; it has priority over every other transition.
- div_stall_o = BUSY | (IDLE & ex_div_op_i & !ex_kill_i). This output is combinational.
- div_result_o holds its last value when not DONE; its value is don't-care while div_done_o=0.

## Timing
- Reset values: state=IDLE, div_stall_o=0 (given ex_div_op_i=0), div_done_o=0, div_result_o=0, counter=0.
- Normal latency, with cycle 0 being the cycle ex_div_op_i is seen in IDLE:
  - BUSY occupies cycles 1–32.
  - DONE at cycle 33.
  - div_stall_o is high in cycles 0–32 and low in cycle 33.
- Kill in cycle k: state is IDLE at k+1. div_stall_o goes low combinationally in cycle k if the kill arrives in the start cycle, otherwise at k+1.
- A new op can start in the cycle after DONE exits.
- Reset asserted mid-operation returns to the reset values immediately; no partial result is ever presented.

## Configuration
- TITAN_DIV_BYPASS_EN defined:
  - Divisor==0 and signed overflow skip BUSY: IDLE goes to DONE directly, with DONE at cycle 1.
  - div_stall_o is high in cycle 0 only.
- Undefined: these cases take the full 33-cycle path.
- Results are bit-identical either way.

## Structure
- The shared defines header holds:
  - the funct encodings (TITAN_DIV_DIV, _DIVU, _REM, _REMU);
  - the state encoding (2-bit: IDLE=0, BUSY=1, DONE=2);
  - the iteration count (32).
- One sub-module, titan_div_datapath, holds the shift-subtract step and the sign fixup.
- The sequencer owns the FSM, the counter and the stall/done logic.

## Test plan
- DIV 100/7 with no stall:
  - div_stall_o high for cycles 0–32.
  - Cycle 33: div_done_o=1, div_result_o=14.
  - IDLE at cycle 34.
- REM 0xFFFFFFF9 (-7) by 2 → 0xFFFFFFFF (-1). REMU with the same operands → 1.
- DIVU 5/0 → 0xFFFFFFFF; REM 5/0 → 5.
  - With TITAN_DIV_BYPASS_EN, done at cycle 1.
  - Without it, done at cycle 33.
- DIV 0x80000000/0xFFFFFFFF → 0x80000000; REM with the same operands → 0.
- Kill:
  - ex_kill_i at cycle 10 → IDLE at 11, div_stall_o=0 at 11, div_done_o never asserts.
  - A new DIV 9/3 issued at cycle 12 gives 3 at cycle 45.
- Downstream stall: mem_stall_i high for 4 cycles starting at DONE.
  - div_done_o=1 and the result holds steady for those 4 cycles.
  - ex_div_op_i is held high throughout and causes no restart.
  - IDLE the cycle after mem_stall_i falls.
